branch_resolve_queue: RTL and testbench

- Resolution-side partner of the tournament chooser.
- Holds each in-flight branch prediction (PC, pshare guess, gshare guess, final guess) in an in-order FIFO until its real outcome arrives.
- On each outcome it generates the training packet that drives the chooser and predictors: fix_result, component predictions and chooser direction.
- Flags mispredicts and keeps saturating hit/miss statistics.

---
 rtl/branch_resolve_queue_if.sv | 49 ++++
 rtl/branch_resolve_queue.sv | 127 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between the branch_resolve_queue and its surroundings.
// The master side offers predictions and outcomes and consumes training packets.
// The slave side is the queue itself.
interface branch_resolve_queue_if #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic          pred_valid;
  logic          pred_ready;
  logic [N-1:0]  pred_pc;
  logic          pred_ph;
  logic          pred_gh;
  logic          pred_final;

  logic          res_valid;
  logic          res_taken;
  logic          res_ready;

  logic          upd_valid;
  logic [N-1:0]  upd_pc;
  logic          upd_taken;
  logic          upd_pred_ph;
  logic          upd_pred_gh;
  logic [1:0]    upd_dir;
  logic          mispredict;

  logic [OW-1:0] occupancy;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output pred_valid, pred_pc, pred_ph, pred_gh, pred_final,
    output res_valid, res_taken,
    input  pred_ready, res_ready,
    input  upd_valid, upd_pc, upd_taken, upd_pred_ph, upd_pred_gh, upd_dir, mispredict,
    input  occupancy, hit_count, miss_count
  );

  modport slave (
    input  pred_valid, pred_pc, pred_ph, pred_gh, pred_final,
    input  res_valid, res_taken,
    output pred_ready, res_ready,
    output upd_valid, upd_pc, upd_taken, upd_pred_ph, upd_pred_gh, upd_dir, mispredict,
    output occupancy, hit_count, miss_count
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. Each resolved outcome pops
// the head entry and produces a registered training packet for the chooser and
// both component predictors, plus saturating hit/miss statistics.
// Optional build macro BRQ_FLUSH_EN: a mispredicting pop also discards every
// younger entry (and any push accepted on the same edge).
module branch_resolve_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic clock,
  input  logic reset,
  branch_resolve_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef struct packed {
    logic [N-1:0] pc;
    logic         ph;
    logic         gh;
    logic         fin;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic             push;
  logic             pop;
  logic             miss_now;
  logic             flush;
  entry_t           head;

  logic             vld_p1;
  logic [N-1:0]     pc_p1;
  logic             taken_p1;
  logic             ph_p1;
  logic             gh_p1;
  logic [1:0]       dir_p1;
  logic             mis_p1;

  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] miss_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Chooser encoding: low states favour pshare, high states favour gshare,
  // so a correct pshare steps down (10) and a correct gshare steps up (01).
  function automatic logic [1:0] chooser_dir(input logic ph, input logic gh,
                                             input logic taken);
    if (ph == gh)         return 2'b00;
    else if (ph == taken) return 2'b10;
    else                  return 2'b01;
  endfunction

  assign bus.pred_ready = (occ < OW'(DEPTH));
  assign bus.res_ready  = (occ != '0);

  assign push     = bus.pred_valid && bus.pred_ready;
  assign pop      = bus.res_valid && bus.res_ready;
  assign head     = mem[rd_ptr];
  assign miss_now = pop && (head.fin != bus.res_taken);

`ifdef BRQ_FLUSH_EN
  assign flush = miss_now;
`else
  assign flush = 1'b0;
`endif

  // Control state: pointers, occupancy, packet valid and statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      vld_p1 <= 1'b0;
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      vld_p1 <= pop;
      if (flush) begin
        // Younger entries and a same-edge push are dropped by catching the
        // read pointer up to the (unadvanced) write pointer.
        rd_ptr <= wr_ptr;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      occ <= occ + OW'(1);
        else if (pop && !push) occ <= occ - OW'(1);
      end
      if (pop) begin
        if (miss_now) miss_q <= sat_inc(miss_q);
        else          hit_q  <= sat_inc(hit_q);
      end
    end
  end

  // Storage and training packet datapath; gated by vld_p1 at the outputs.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{pc: bus.pred_pc, ph: bus.pred_ph,
                               gh: bus.pred_gh, fin: bus.pred_final};
    // stage p1: registered training packet
    if (pop) begin
      pc_p1    <= head.pc;
      taken_p1 <= bus.res_taken;
      ph_p1    <= head.ph;
      gh_p1    <= head.gh;
      dir_p1   <= chooser_dir(head.ph, head.gh, bus.res_taken);
      mis_p1   <= miss_now;
    end
  end

  assign bus.upd_valid   = vld_p1;
  assign bus.upd_pc      = vld_p1 ? pc_p1 : '0;
  assign bus.upd_taken   = vld_p1 & taken_p1;
  assign bus.upd_pred_ph = vld_p1 & ph_p1;
  assign bus.upd_pred_gh = vld_p1 & gh_p1;
  assign bus.upd_dir     = vld_p1 ? dir_p1 : 2'b00;
  assign bus.mispredict  = vld_p1 & mis_p1;
  assign bus.occupancy   = occ;
  assign bus.hit_count   = hit_q;
  assign bus.miss_count  = miss_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model. A second instance
// with 2-bit counters shares the stimulus to exercise saturation.
module tb_branch_resolve_queue;
  localparam int N     = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam int CNT_S = 2;
  localparam longint SMAX = (64'd1 << CNT_S) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  branch_resolve_queue_if #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  branch_resolve_queue_if #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_S)) bus_s ();

  branch_resolve_queue #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));
  branch_resolve_queue #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_S)) dut_s (
    .clock(clock), .reset(reset), .bus(bus_s.slave));

  assign bus_s.pred_valid = bus.pred_valid;
  assign bus_s.pred_pc    = bus.pred_pc;
  assign bus_s.pred_ph    = bus.pred_ph;
  assign bus_s.pred_gh    = bus.pred_gh;
  assign bus_s.pred_final = bus.pred_final;
  assign bus_s.res_valid  = bus.res_valid;
  assign bus_s.res_taken  = bus.res_taken;

  typedef struct {
    logic [N-1:0] pc;
    logic ph, gh, fin;
  } ent_t;

  ent_t   q[$];
  longint hits, misses;
  int     n_err = 0;
  int     n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model is advanced and every output compared.
  task automatic step(input logic rst, input logic pv, input logic [N-1:0] pc,
                      input logic ph, input logic gh, input logic fin,
                      input logic rv, input logic rt);
    ent_t e;
    bit push_ok, pop_ok, dropped;
    logic ev, et, eph, egh, emis;
    logic [N-1:0] epc;
    logic [1:0] edir;
    @(negedge clock);
    reset = rst;
    bus.pred_valid = pv; bus.pred_pc = pc; bus.pred_ph = ph;
    bus.pred_gh = gh; bus.pred_final = fin;
    bus.res_valid = rv; bus.res_taken = rt;
    ev = 0; et = 0; eph = 0; egh = 0; emis = 0; epc = '0; edir = 2'b00;
    if (rst) begin
      q.delete(); hits = 0; misses = 0;
    end else begin
      push_ok = pv && (q.size() < DEPTH);
      pop_ok  = rv && (q.size() != 0);
      dropped = 0;
      if (pop_ok) begin
        e = q.pop_front();
        ev = 1; epc = e.pc; et = rt; eph = e.ph; egh = e.gh;
        if (e.ph == e.gh)  edir = 2'b00;
        else if (e.ph == rt) edir = 2'b10;
        else               edir = 2'b01;
        emis = (e.fin != rt);
        if (emis) misses++; else hits++;
`ifdef BRQ_FLUSH_EN
        if (emis) begin q.delete(); dropped = 1; end
`endif
      end
      if (push_ok && !dropped) q.push_back('{pc: pc, ph: ph, gh: gh, fin: fin});
    end
    @(posedge clock);
    #1;
    chk("upd_valid",  bus.upd_valid, ev);
    chk("upd_pc",     bus.upd_pc, epc);
    chk("upd_taken",  bus.upd_taken, et);
    chk("upd_ph",     bus.upd_pred_ph, eph);
    chk("upd_gh",     bus.upd_pred_gh, egh);
    chk("upd_dir",    bus.upd_dir, edir);
    chk("mispredict", bus.mispredict, emis);
    chk("occupancy",  bus.occupancy, q.size());
    chk("pred_ready", bus.pred_ready, q.size() < DEPTH);
    chk("res_ready",  bus.res_ready, q.size() != 0);
    chk("hit_count",  bus.hit_count, hits);
    chk("miss_count", bus.miss_count, misses);
    chk("hit_sat",    bus_s.hit_count, (hits > SMAX) ? SMAX : hits);
    chk("miss_sat",   bus_s.miss_count, (misses > SMAX) ? SMAX : misses);
    chk("upd_valid_s", bus_s.upd_valid, ev);
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, 0, 0, 0, 0);
  endtask
  task automatic push(input logic [N-1:0] pc, input logic ph, input logic gh, input logic fin);
    step(0, 1, pc, ph, gh, fin, 0, 0);
  endtask
  task automatic pop(input logic rt);
    step(0, 0, '0, 0, 0, 0, 1, rt);
  endtask

  function automatic logic head_fin();
    return (q.size() != 0) ? q[0].fin : 1'b0;
  endfunction

  initial begin
    logic rt;
    logic [N-1:0] pc;
    do_reset();
    do_reset();

    // Single correct branch
    push(32'h100, 1, 0, 1);
    pop(1);
    chk("t1_pc",  bus.upd_pc, 32'h100);
    chk("t1_dir", bus.upd_dir, 2'b10);
    chk("t1_hit", bus.hit_count, 1);

    // Fill, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) push(N'(i * 4), i[0], i[1], i[0]);
    chk("full_ready", bus.pred_ready, 0);
    chk("full_occ",   bus.occupancy, DEPTH);
    push(32'h200, 1, 1, 1);
    chk("full_occ2",  bus.occupancy, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      pop(head_fin() ^ 1'b0);
      chk("drain_pc", bus.upd_pc, N'(i * 4));
    end
    chk("drain_occ", bus.occupancy, 0);
    chk("drain_res_ready", bus.res_ready, 0);

    // Simultaneous push/pop at occupancy 3, then wrap with mixed traffic
    for (int i = 0; i < 3; i++) push(N'(32'h300 + i), 1, 0, 1);
    step(0, 1, 32'h400, 0, 1, 0, 1, head_fin());
    chk("pp_occ", bus.occupancy, 3);
    for (int i = 0; i < 20; i++) begin
      pc = N'(32'h500 + i);
      step(0, (i % 3) != 2, pc, 1, 0, 1, (i % 2) == 0, head_fin());
    end
    while (q.size() != 0) pop(head_fin());

    // Mispredict at the head with three younger entries
    do_reset();
    push(32'h600, 0, 1, 0);
    for (int i = 1; i < 4; i++) push(N'(32'h600 + 4 * i), 1, 1, 1);
    pop(1);
    chk("mp_dir",  bus.upd_dir, 2'b01);
    chk("mp_mis",  bus.mispredict, 1);
    chk("mp_miss", bus.miss_count, 1);
`ifdef BRQ_FLUSH_EN
    chk("mp_occ",  bus.occupancy, 0);
`else
    chk("mp_occ",  bus.occupancy, 3);
`endif

    // Reset mid-stream with a pop in flight
    do_reset();
    for (int i = 0; i < 5; i++) push(N'(32'h700 + 4 * i), 0, 0, 0);
    pop(0);
    step(1, 1, 32'h7FC, 1, 1, 1, 1, 0);
    chk("rst_upd_valid", bus.upd_valid, 0);
    chk("rst_occ",       bus.occupancy, 0);
    chk("rst_hits",      bus.hit_count, 0);
    chk("rst_pred_ready", bus.pred_ready, 1);

    // Saturation of the narrow instance
    for (int i = 0; i < 5; i++) push(N'(32'h800 + 4 * i), 1, 0, 1);
    for (int i = 0; i < 5; i++) pop(1);
    chk("sat_hit",  bus_s.hit_count, 3);
    chk("wide_hit", bus.hit_count, 5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rt = ($urandom_range(0, 3) != 0) ? head_fin() : 1'($urandom);
      step(($urandom_range(0, 63) == 0), 1'($urandom), $urandom,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rt);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
